// File: rtl/fpu_fma_writeback.sv
// fpu_fma_writeback: writeback collector for the fixed-latency FMA pipe.
//   Tags each issued op through a LATENCY-deep {valid, rd} pipe, captures the
//   pipe's result and flags when the tag emerges, buffers them in a DEPTH-entry
//   FIFO and presents them to the FP register file with valid/ready. Issue is
//   credit-limited so a captured result always has a FIFO slot.
// Ports:
//   clock, reset             clock and asynchronous active-low reset
//   io_issue_valid/rd/ready  issue handshake into the FMA pipe
//   io_fma_data/exc          pipe result and flags, sampled when the tag emerges
//   io_kill                  flush of all in-flight and buffered ops
//   io_wb_valid/ready        writeback handshake; io_wb_rd/data/exc is the head entry
//   io_fflags_clear          clear sticky flags
//   io_fflags                sticky flags accumulated over writebacks
//   io_busy                  any op in flight or buffered
module fpu_fma_writeback #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_issue_valid,
    input  logic [4:0]  io_issue_rd,
    output logic        io_issue_ready,
    input  logic [32:0] io_fma_data,
    input  logic [4:0]  io_fma_exc,
    input  logic        io_kill,
    output logic        io_wb_valid,
    input  logic        io_wb_ready,
    output logic [4:0]  io_wb_rd,
    output logic [32:0] io_wb_data,
    output logic [4:0]  io_wb_exc,
    input  logic        io_fflags_clear,
    output logic [4:0]  io_fflags,
    output logic        io_busy
);
    localparam int CW = $clog2(DEPTH + 1) + 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [32:0] data;
        logic [4:0]  exc;
    } entry_t;

    logic [LATENCY-1:0] tag_v_q;
    logic [4:0]         tag_rd_q [LATENCY];
    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      occ_q, occ_d, cnt_q, cnt_d;
    logic [4:0]         fflags_q, fflags_d;
    logic               issue_fire, push, pop;
    entry_t             head;

    // Ready looks only at the registered count; a same-cycle pop frees no credit.
    assign io_issue_ready = (cnt_q < CW'(DEPTH)) & ~io_kill;
    assign issue_fire     = io_issue_valid & io_issue_ready;
    assign push           = tag_v_q[LATENCY-1] & ~io_kill;
    assign io_wb_valid    = occ_q != '0;
    assign pop            = io_wb_valid & io_wb_ready & ~io_kill;
    assign head           = io_wb_valid ? mem_q[rptr_q] : '0;
    assign io_wb_rd       = head.rd;
    assign io_wb_data     = head.data;
    assign io_wb_exc      = head.exc;
    assign io_fflags      = fflags_q;
    assign io_busy        = cnt_q != '0;

    always_comb begin
        wptr_d   = push ? ((wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d   = pop ? ((rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        occ_d    = occ_q + CW'(push) - CW'(pop);
        cnt_d    = cnt_q + CW'(issue_fire) - CW'(pop);
        fflags_d = pop ? ((io_fflags_clear ? 5'd0 : fflags_q) | head.exc)
                       : (io_fflags_clear ? 5'd0 : fflags_q);
        if (io_kill) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            if (io_kill) tag_v_q <= '0;
            else begin
                tag_v_q[0] <= issue_fire;
                for (int i = 1; i < LATENCY; i++) tag_v_q[i] <= tag_v_q[i-1];
            end
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
        end
    end

    // Payload storage needs no reset: tag valids and occupancy gate its use.
    always_ff @(posedge clock) begin
        tag_rd_q[0] <= io_issue_rd;
        for (int i = 1; i < LATENCY; i++) tag_rd_q[i] <= tag_rd_q[i-1];
        if (push) mem_q[wptr_q] <= '{rd: tag_rd_q[LATENCY-1], data: io_fma_data, exc: io_fma_exc};
    end
endmodule

// File: tb/tb_fpu_fma_writeback.sv
module tb_fpu_fma_writeback;
    localparam int LAT = 3;
    localparam int DEP = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_issue_valid = 1'b0;
    logic [4:0]  io_issue_rd = '0;
    logic        io_issue_ready;
    logic [32:0] io_fma_data = '0;
    logic [4:0]  io_fma_exc = '0;
    logic        io_kill = 1'b0;
    logic        io_wb_valid;
    logic        io_wb_ready = 1'b0;
    logic [4:0]  io_wb_rd;
    logic [32:0] io_wb_data;
    logic [4:0]  io_wb_exc;
    logic        io_fflags_clear = 1'b0;
    logic [4:0]  io_fflags;
    logic        io_busy;

    fpu_fma_writeback #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset),
        .io_issue_valid(io_issue_valid), .io_issue_rd(io_issue_rd), .io_issue_ready(io_issue_ready),
        .io_fma_data(io_fma_data), .io_fma_exc(io_fma_exc), .io_kill(io_kill),
        .io_wb_valid(io_wb_valid), .io_wb_ready(io_wb_ready), .io_wb_rd(io_wb_rd),
        .io_wb_data(io_wb_data), .io_wb_exc(io_wb_exc),
        .io_fflags_clear(io_fflags_clear), .io_fflags(io_fflags), .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        logic [4:0]  rd;
        logic [32:0] data;
        logic [4:0]  exc;
    } op_t;

    op_t         pipe[$];
    op_t         fifo[$];
    logic [4:0]  m_ff = '0;
    int unsigned cyc = 0;
    logic [32:0] nd;
    logic [4:0]  ne;
    int          checks = 0;
    int          fails = 0;

    wire [50:0] obs = {io_issue_ready, io_wb_valid, io_wb_rd, io_wb_data, io_wb_exc, io_fflags, io_busy};

    function automatic logic [50:0] exp_vec();
        logic [49:0] rest;
        int          n;
        n = pipe.size() + fifo.size();
        rest = {1'b0, 5'd0, 33'd0, 5'd0, m_ff, n != 0};
        if (fifo.size() > 0) rest = {1'b1, fifo[0].rd, fifo[0].data, fifo[0].exc, m_ff, 1'b1};
        return {(n < DEP) && !io_kill, rest};
    endfunction

    function automatic bit can_issue();
        return (pipe.size() + fifo.size() < DEP) && !io_kill;
    endfunction

    task automatic set_in(input logic v, input logic [4:0] rd, input logic [32:0] d, input logic [4:0] e,
                          input logic k, input logic wr, input logic clr);
        io_issue_valid = v; io_issue_rd = rd; nd = d; ne = e;
        io_kill = k; io_wb_ready = wr; io_fflags_clear = clr;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            io_fma_data = pipe[0].data;
            io_fma_exc  = pipe[0].exc;
        end else begin
            io_fma_data = {1'($urandom), 32'($urandom)};
            io_fma_exc  = 5'($urandom);
        end
        #1;
    endtask

    task automatic advance();
        bit  fi, fw;
        op_t o;
        fi = io_issue_valid && can_issue();
        fw = fifo.size() > 0 && io_wb_ready && !io_kill;
        @(posedge clock);
        if (fw) m_ff = (io_fflags_clear ? 5'd0 : m_ff) | fifo[0].exc;
        else if (io_fflags_clear) m_ff = 5'd0;
        if (io_kill) begin
            pipe.delete();
            fifo.delete();
        end else begin
            if (fw) void'(fifo.pop_front());
            if (pipe.size() > 0 && pipe[0].due == cyc) fifo.push_back(pipe.pop_front());
            if (fi) begin
                o.due = cyc + LAT; o.rd = io_issue_rd; o.data = nd; o.exc = ne;
                pipe.push_back(o);
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== {1'b1, 50'd0}) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", obs, {1'b1, 50'd0});
        end
        @(negedge clock);
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 6; c++) begin
            set_in(c == 0, 5'd5, 33'h0_3F800000, 5'h00, 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL single_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            checks++;
            if (io_wb_valid !== (c == 4)) begin
                fails++;
                $display("FAIL single_valid c%0d: got %b want %b", c, io_wb_valid, c == 4);
            end
            if (c == 4) begin
                checks++;
                if ({io_wb_rd, io_wb_data} !== {5'd5, 33'h0_3F800000}) begin
                    fails++;
                    $display("FAIL single_entry: got rd=%0d data=%h want rd=5 data=03f800000", io_wb_rd, io_wb_data);
                end
            end
            if (c >= 4) begin
                checks++;
                if (io_busy !== (c == 4)) begin
                    fails++;
                    $display("FAIL single_busy c%0d: got %b want %b", c, io_busy, c == 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 11; c++) begin
            set_in(c < 8, (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd7, 33'($urandom), 5'd0, 0, c >= 8, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL bp_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            if (c >= 2 && c <= 9) begin
                checks++;
                if (io_issue_ready !== (c == 9)) begin
                    fails++;
                    $display("FAIL bp_ready c%0d: got %b want %b", c, io_issue_ready, c == 9);
                end
            end
            if (c == 8 || c == 9) begin
                checks++;
                if ({io_wb_valid, io_wb_rd} !== {1'b1, 5'(c - 7)}) begin
                    fails++;
                    $display("FAIL bp_pop c%0d: got v=%b rd=%0d want v=1 rd=%0d", c, io_wb_valid, io_wb_rd, c - 7);
                end
            end
            advance();
        end
    endtask

    task automatic test_fflags();
        set_in(0, 0, 0, 0, 0, 1, 1);
        advance();
        for (int c = 0; c < 8; c++) begin
            set_in(c < 2, 5'(c + 10), 33'($urandom), (c == 0) ? 5'h01 : 5'h04, 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL ff_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            advance();
        end
        checks++;
        if (io_fflags !== 5'h05) begin
            fails++;
            $display("FAIL ff_accum: got %h want 05", io_fflags);
        end
        for (int c = 0; c < 6; c++) begin
            set_in(c == 0, 5'd12, 33'($urandom), 5'h10, 0, 1, fifo.size() > 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL ff_clr_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            advance();
        end
        checks++;
        if (io_fflags !== 5'h10) begin
            fails++;
            $display("FAIL ff_clear_fire: got %h want 10", io_fflags);
        end
        set_in(0, 0, 0, 0, 0, 1, 1);
        advance();
        set_in(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (io_fflags !== 5'h00) begin
            fails++;
            $display("FAIL ff_clear_only: got %h want 00", io_fflags);
        end
    endtask

    task automatic test_kill();
        for (int c = 0; c < 9; c++) begin
            set_in(c == 0 || c == 3, (c == 0) ? 5'd3 : 5'd9, 33'($urandom), 5'd0, c == 2, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL kill_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            if (c == 3) begin
                checks++;
                if ({io_issue_ready, io_busy} !== 2'b10) begin
                    fails++;
                    $display("FAIL kill_after: got ready=%b busy=%b want ready=1 busy=0", io_issue_ready, io_busy);
                end
            end
            checks++;
            if (io_wb_valid !== (c == 7) || (c == 7 && io_wb_rd !== 5'd9)) begin
                fails++;
                $display("FAIL kill_wb c%0d: got v=%b rd=%0d want v=%b rd=9", c, io_wb_valid, io_wb_rd, c == 7);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] iss[$];
        logic [4:0] got[$];
        for (int c = 0; c < 40; c++) begin
            set_in(c < 30, 5'(c), {1'($urandom), 32'($urandom)}, 5'($urandom), 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL b2b_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            if (io_issue_valid && can_issue()) iss.push_back(io_issue_rd);
            if (io_wb_valid && io_wb_ready) got.push_back(io_wb_rd);
            advance();
        end
        checks++;
        if (got.size() < 6 || got.size() != iss.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d writebacks want %0d (>=6)", got.size(), iss.size());
        end
        for (int i = 0; i < got.size() && i < iss.size(); i++) begin
            checks++;
            if (got[i] !== iss[i]) begin
                fails++;
                $display("FAIL b2b_order %0d: got rd=%0d want rd=%0d", i, got[i], iss[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            set_in(1'($urandom), 5'($urandom), {1'($urandom), 32'($urandom)}, 5'($urandom),
                   $urandom_range(31) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rand_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            advance();
        end
        for (int c = 0; c < 8; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            advance();
        end
    endtask

    task automatic test_reset_midrun();
        for (int c = 0; c < 6; c++) begin
            set_in(c == 0, 5'd4, 33'($urandom), 5'h1F, 0, 1, 0);
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            set_in(c < 2, 5'(c + 20), 33'($urandom), 5'd0, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL mid_model c%0d: got %h want %h", c, obs, exp_vec());
            end
            if (c < 2) advance();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 50'd0}) begin
            fails++;
            $display("FAIL mid_reset_async: got %h want %h", obs, {1'b1, 50'd0});
        end
        pipe.delete();
        fifo.delete();
        m_ff = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc += 2;
        set_in(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== {1'b1, 50'd0}) begin
            fails++;
            $display("FAIL mid_reset_release: got %h want %h", obs, {1'b1, 50'd0});
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_backpressure();
        test_fflags();
        test_kill();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/fpu_fma_writeback.md
# fpu_fma_writeback

Writeback collector for the FMA pipe. Tracks each operation issued into the FMA pipe through a fixed-latency tag pipeline. Captures the pipe's result and exception flags when that operation emerges and buffers them in a small FIFO. Presents them to the FP register-file write port with a valid/ready handshake and accumulates sticky fflags. Issue is credit-limited so no result from the fixed-latency pipe is ever lost.

## Interface
Parameters:
- LATENCY, 3, cycles from issue into the FMA pipe to its result being valid on io_fma_data/io_fma_exc (≥1)
- DEPTH, 2, result FIFO entries; also the maximum number of operations in flight plus buffered (≥1)

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset); deassertion is synchronous to clock externally
- io_issue_valid  input  1  an FMA op is presented to the FMA pipe this cycle
- io_issue_rd  input  5  destination register of the issued op
- io_issue_ready  output  1  issue permitted; an op is accepted when valid & ready
- io_fma_data  input  33  recoded FMA result
- io_fma_exc  input  5  FMA exception flags
- io_kill  input  1  synchronous flush of all in-flight and buffered ops
- io_wb_valid  output  1  writeback entry available
- io_wb_ready  input  1  register file accepts entry
- io_wb_rd  output  5  writeback destination
- io_wb_data  output  33  writeback data
- io_wb_exc  output  5  flags of the head entry
- io_fflags_clear  input  1  clear accumulated flags
- io_fflags  output  5  sticky accumulated flags
- io_busy  output  1  any op in flight or buffered

## Operation
- Tag pipe: LATENCY registers of {valid, rd}. Stage 0 loads {issue fire, io_issue_rd}; each stage shifts every cycle unconditionally.
- Capture: when the last tag stage is valid, {rd, io_fma_data, io_fma_exc} is pushed into the FIFO at that clock edge. io_fma_data/exc are don't-care otherwise.
- FIFO: DEPTH entries, in order; circular read/write pointers with wrap at DEPTH. Push and pop in the same cycle are both performed. Overflow is impossible by construction.
- Credit counter: count = tags in flight + FIFO occupancy, width clog2(DEPTH+1)+1. The counter is incremented on issue fire and decremented on wb pop; both in the same cycle leave it unchanged.
- io_issue_ready = (count < DEPTH) & ~io_kill. It is combinational from the registered count only; a pop in the same cycle does not raise ready.
- io_wb_valid = FIFO not empty. io_wb_rd/data/exc show the head entry; they are zero when empty.
- fflags: on wb fire, fflags ← (io_fflags_clear ? 0 : fflags) | io_wb_exc. Clear without fire gives 0. Clear does not depend on kill.
- Kill: at the edge, all tag valids, FIFO pointers/occupancy, and count are zeroed. Issue and wb fire in the kill cycle are discarded, and fflags is not updated by them. The io_wb_valid output is still combinational from the pre-kill state in that cycle.
- io_busy = count != 0.

## Timing
- Reset (reset=0, asynchronous): tags invalid, FIFO empty, count 0, fflags 0. Outputs are immediately io_issue_ready=1, io_wb_valid=0, io_wb_rd/data/exc=0, io_fflags=0, io_busy=0.
- An op issued in cycle T is captured at the end of cycle T+LATENCY. io_wb_valid is high from cycle T+LATENCY+1. Minimum issue-to-writeback latency is LATENCY+1.
- Back-to-back issue is sustained at 1/cycle while credit allows. Full throughput requires DEPTH ≥ LATENCY+1.
- With io_wb_ready held 1, each entry is visible for exactly one cycle.
- Entries hold stable while io_wb_valid & ~io_wb_ready.

## Test plan
- Reset: assert reset=0 mid-run with 2 ops in flight -> outputs clear in the same cycle without an edge. After release: ready=1, busy=0, fflags=0x00.
- Single op (LATENCY=3, DEPTH=2): issue rd=5 at cycle 0, drive io_fma_data=0x0_3F800000, exc=0x00 at cycle 3, wb_ready=1 -> wb_valid=1 only at cycle 4 with rd=5, data=0x0_3F800000; busy falls at cycle 5.
- Backpressure: wb_ready=0, issue rd=1 (cycle 0) and rd=2 (cycle 1) -> ready=0 from cycle 2, a third valid is not accepted. Raise wb_ready at cycle 8 -> rd=1 pops at cycle 8, rd=2 at cycle 9; ready returns 1 at cycle 9.
- fflags: results with exc 0x01 then 0x04 written back -> fflags=0x05. Clear asserted with a wb fire of exc 0x10 -> fflags=0x10. Clear alone -> 0x00.
- Kill: issue rd=3 at cycle 0, io_kill=1 at cycle 2 -> no wb_valid ever for rd=3, count=0, ready=1 at cycle 3. A new issue at cycle 3 writes back normally at cycle 7.
- Simultaneous push/pop with DEPTH=2: continuous issue with wb_ready=1 -> pointer wraparound is exercised over ≥6 ops, results emerge in issue order with no drops.
